// File: rtl/credit_controller.sv
// rtl/credit_controller.sv - coin credit accumulator with priced vend slots and serial change dispense
//
// Purpose:
//   Tracks inserted credit, holds a programmable price per product slot,
//   grants or refuses vends against that price, and refunds credit one unit
//   per cycle as change pulses.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   mode, value, value_valid      mode 0 inserts a coin of 'value'; mode 1 programs price[slot]
//   slot                          slot index for price programming and vending
//   vend_req, refund_req          single-cycle requests
//   credit                        current credit
//   vend_ok, vend_fail            single-cycle vend result pulses
//   overflow                      single-cycle pulse when a coin would exceed the credit range
//   change_pulse                  one pulse per unit of credit refunded
//   busy                          high while change is being dispensed
module credit_controller #(
   parameter int VALUE_W   = 4,
   parameter int CREDIT_W  = 8,
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mode,
   input  logic [VALUE_W-1:0]  value,
   input  logic                value_valid,
   input  logic [SLOT_W-1:0]   slot,
   input  logic                vend_req,
   input  logic                refund_req,
   output logic [CREDIT_W-1:0] credit,
   output logic                vend_ok,
   output logic                vend_fail,
   output logic                overflow,
   output logic                change_pulse,
   output logic                busy
);

   typedef enum logic [0:0] {IDLE, DISPENSE} state_t;

   localparam logic [CREDIT_W:0]  CREDIT_MAX  = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [VALUE_W-1:0] PRICE_RST   = {VALUE_W{1'b1}};
   localparam logic [SLOT_W:0]    NUM_SLOTS_W = (SLOT_W+1)'(NUM_SLOTS);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                busy_q, busy_d;
   logic                vend_ok_q, vend_ok_d;
   logic                vend_fail_q, vend_fail_d;
   logic                overflow_q, overflow_d;
   logic                change_pulse_q, change_pulse_d;
   logic [VALUE_W-1:0]  price_q [NUM_SLOTS];
   logic [VALUE_W-1:0]  price_d [NUM_SLOTS];

   logic                slot_ok;
   logic [VALUE_W-1:0]  sel_price;
   logic [CREDIT_W:0]   credit_ext;
   logic [CREDIT_W:0]   coin_sum;
   logic [CREDIT_W:0]   price_ext;

   always_comb begin
      slot_ok = ({1'b0, slot} < NUM_SLOTS_W);

      // Mux rather than direct indexing so an out-of-range slot never reads X.
      sel_price = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot == SLOT_W'(i)) sel_price = price_q[i];
      end

      // One extra bit so a coin that would exceed the range is detected, not wrapped.
      credit_ext = {1'b0, credit_q};
      coin_sum   = credit_ext + (CREDIT_W+1)'(value);
      price_ext  = (CREDIT_W+1)'(sel_price);

      state_d        = state_q;
      credit_d       = credit_q;
      busy_d         = 1'b0;
      vend_ok_d      = 1'b0;
      vend_fail_d    = 1'b0;
      overflow_d     = 1'b0;
      change_pulse_d = 1'b0;
      price_d        = price_q;

      case (state_q)
         IDLE: begin
            // Only the highest-priority request acts; the rest are dropped.
            if (refund_req) begin
               if (credit_q != '0) begin
                  state_d = DISPENSE;
                  busy_d  = 1'b1;
               end
            end else if (vend_req) begin
               if (slot_ok && (credit_ext >= price_ext)) begin
                  credit_d  = credit_q - CREDIT_W'(sel_price);
                  vend_ok_d = 1'b1;
               end else begin
                  vend_fail_d = 1'b1;
               end
            end else if (value_valid) begin
               if (mode) begin
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     if (slot_ok && (slot == SLOT_W'(i))) price_d[i] = value;
                  end
               end else if (coin_sum > CREDIT_MAX) begin
                  overflow_d = 1'b1;
               end else begin
                  // A zero coin lands here and leaves credit unchanged.
                  credit_d = coin_sum[CREDIT_W-1:0];
               end
            end
         end
         DISPENSE: begin
            // Requests are ignored here; credit drains one unit per cycle.
            if (credit_q != '0) begin
               credit_d       = credit_q - CREDIT_W'(1);
               change_pulse_d = 1'b1;
               busy_d         = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         busy_q         <= 1'b0;
         vend_ok_q      <= 1'b0;
         vend_fail_q    <= 1'b0;
         overflow_q     <= 1'b0;
         change_pulse_q <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) price_q[i] <= PRICE_RST;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         busy_q         <= busy_d;
         vend_ok_q      <= vend_ok_d;
         vend_fail_q    <= vend_fail_d;
         overflow_q     <= overflow_d;
         change_pulse_q <= change_pulse_d;
         price_q        <= price_d;
      end
   end

   assign credit       = credit_q;
   assign busy         = busy_q;
   assign vend_ok      = vend_ok_q;
   assign vend_fail    = vend_fail_q;
   assign overflow     = overflow_q;
   assign change_pulse = change_pulse_q;

endmodule

// File: tb/tb_credit_controller.sv
// tb/tb_credit_controller.sv - directed self-checking bench for credit_controller
module tb_credit_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode = 1'b0;
   logic [3:0] value = '0;
   logic       value_valid = 1'b0;
   logic [1:0] slot = '0;
   logic       vend_req = 1'b0;
   logic       refund_req = 1'b0;
   logic [7:0] credit;
   logic       vend_ok, vend_fail, overflow, change_pulse, busy;

   int checks = 0;
   int errors = 0;

   credit_controller #(.VALUE_W(4), .CREDIT_W(8), .NUM_SLOTS(4), .SLOT_W(2)) dut (
      .clock(clock), .reset(reset), .mode(mode), .value(value), .value_valid(value_valid),
      .slot(slot), .vend_req(vend_req), .refund_req(refund_req), .credit(credit),
      .vend_ok(vend_ok), .vend_fail(vend_fail), .overflow(overflow),
      .change_pulse(change_pulse), .busy(busy)
   );

   always #5 clock = ~clock;

   // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
   task automatic apply(input logic m, input logic [3:0] v, input logic vv,
                        input logic [1:0] s, input logic vr, input logic rr);
      mode = m; value = v; value_valid = vv; slot = s; vend_req = vr; refund_req = rr;
      @(posedge clock); #1;
      value_valid = 1'b0; vend_req = 1'b0; refund_req = 1'b0; value = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if ({credit, busy, vend_ok, vend_fail, overflow, change_pulse} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got credit=%0d busy=%b ok=%b fail=%b ovf=%b chg=%b, expected all 0",
                  credit, busy, vend_ok, vend_fail, overflow, change_pulse);
      end
      do_reset();
   endtask

   task automatic test_insert();
      apply(1'b0, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd15 || {overflow, vend_ok, vend_fail} !== 3'b000) begin
         errors++;
         $display("FAIL insert_15: got credit=%0d flags=%b%b%b, expected 15 000", credit, overflow, vend_ok, vend_fail);
      end
      apply(1'b0, 4'd12, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd27 || {overflow, vend_ok, vend_fail} !== 3'b000) begin
         errors++;
         $display("FAIL insert_12: got credit=%0d flags=%b%b%b, expected 27 000", credit, overflow, vend_ok, vend_fail);
      end
      apply(1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd27 || {overflow, vend_ok, vend_fail} !== 3'b000) begin
         errors++;
         $display("FAIL insert_zero: got credit=%0d flags=%b%b%b, expected 27 000", credit, overflow, vend_ok, vend_fail);
      end
   endtask

   task automatic test_price_vend();
      do_reset();
      apply(1'b1, 4'd12, 1'b1, 2'd2, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd0) begin
         errors++;
         $display("FAIL program_credit: got %0d, expected 0", credit);
      end
      apply(1'b0, 4'd10, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0);
      checks++;
      if (vend_fail !== 1'b1 || vend_ok !== 1'b0 || credit !== 8'd10) begin
         errors++;
         $display("FAIL vend_short: got fail=%b ok=%b credit=%0d, expected 1 0 10", vend_fail, vend_ok, credit);
      end
      apply(1'b0, 4'd5, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (vend_fail !== 1'b0 || credit !== 8'd15) begin
         errors++;
         $display("FAIL vend_fail_pulse: got fail=%b credit=%0d, expected 0 15", vend_fail, credit);
      end
      apply(1'b0, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0);
      checks++;
      if (vend_ok !== 1'b1 || vend_fail !== 1'b0 || credit !== 8'd3) begin
         errors++;
         $display("FAIL vend_good: got ok=%b fail=%b credit=%0d, expected 1 0 3", vend_ok, vend_fail, credit);
      end
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (vend_fail !== 1'b1 || vend_ok !== 1'b0 || credit !== 8'd3) begin
         errors++;
         $display("FAIL vend_default_price: got fail=%b ok=%b credit=%0d, expected 1 0 3", vend_fail, vend_ok, credit);
      end
      apply(1'b1, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 2'd1, 1'b1, 1'b0);
      checks++;
      if (vend_ok !== 1'b1 || credit !== 8'd3) begin
         errors++;
         $display("FAIL vend_price_zero: got ok=%b credit=%0d, expected 1 3", vend_ok, credit);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) apply(1'b0, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd10, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (credit !== 8'd250) begin
         errors++;
         $display("FAIL overflow_setup: got credit=%0d, expected 250", credit);
      end
      apply(1'b0, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1 || credit !== 8'd250) begin
         errors++;
         $display("FAIL overflow_pulse: got ovf=%b credit=%0d, expected 1 250", overflow, credit);
      end
      apply(1'b0, 4'd5, 1'b1, 2'd0, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b0 || credit !== 8'd255) begin
         errors++;
         $display("FAIL overflow_fill_max: got ovf=%b credit=%0d, expected 0 255", overflow, credit);
      end
   endtask

   task automatic test_refund();
      do_reset();
      apply(1'b0, 4'd3, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1 || change_pulse !== 1'b0 || credit !== 8'd3) begin
         errors++;
         $display("FAIL refund_enter: got busy=%b chg=%b credit=%0d, expected 1 0 3", busy, change_pulse, credit);
      end
      for (int k = 1; k <= 3; k++) begin
         // Vend request while busy must not produce any flag.
         apply(1'b0, 4'd0, 1'b0, 2'd0, (k == 1), 1'b0);
         checks++;
         if (change_pulse !== 1'b1 || busy !== 1'b1 || credit !== 8'(3 - k) || {vend_ok, vend_fail} !== 2'b00) begin
            errors++;
            $display("FAIL refund_step%0d: got chg=%b busy=%b credit=%0d vend=%b%b, expected 1 1 %0d 00",
                     k, change_pulse, busy, credit, vend_ok, vend_fail, 3 - k);
         end
      end
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || change_pulse !== 1'b0 || credit !== 8'd0) begin
         errors++;
         $display("FAIL refund_exit: got busy=%b chg=%b credit=%0d, expected 0 0 0", busy, change_pulse, credit);
      end
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b0 || change_pulse !== 1'b0) begin
         errors++;
         $display("FAIL refund_zero_credit: got busy=%b chg=%b, expected 0 0", busy, change_pulse);
      end
   endtask

   task automatic test_reset_mid_dispense();
      do_reset();
      apply(1'b1, 4'd3, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd9, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || credit !== 8'd8) begin
         errors++;
         $display("FAIL midreset_setup: got busy=%b credit=%0d, expected 1 8", busy, credit);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (credit !== 8'd0 || busy !== 1'b0 || change_pulse !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: got credit=%0d busy=%b chg=%b, expected 0 0 0", credit, busy, change_pulse);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (change_pulse !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
         errors++;
         $display("FAIL midreset_after: got chg=%b busy=%b credit=%0d, expected 0 0 0", change_pulse, busy, credit);
      end
      apply(1'b0, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (vend_ok !== 1'b1 || credit !== 8'd0) begin
         errors++;
         $display("FAIL midreset_price_restored: got ok=%b credit=%0d, expected 1 0", vend_ok, credit);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int cycles;
      logic saw_flag;
      do_reset();
      apply(1'b1, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      apply(1'b0, 4'd5, 1'b1, 2'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd3, 1'b1, 2'd1, 1'b1, 1'b1);
      checks++;
      if (busy !== 1'b1 || credit !== 8'd5 || {vend_ok, vend_fail, overflow} !== 3'b000) begin
         errors++;
         $display("FAIL b2b_priority: got busy=%b credit=%0d flags=%b%b%b, expected 1 5 000",
                  busy, credit, vend_ok, vend_fail, overflow);
      end
      pulses = 0;
      cycles = 0;
      saw_flag = 1'b0;
      while (busy === 1'b1 && cycles < 20) begin
         apply(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
         cycles++;
         if (change_pulse === 1'b1) pulses++;
         if (vend_ok === 1'b1 || vend_fail === 1'b1) saw_flag = 1'b1;
      end
      checks++;
      if (pulses != 5 || saw_flag !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
         errors++;
         $display("FAIL b2b_pulses: got pulses=%0d vendflag=%b busy=%b credit=%0d after %0d cycles, expected 5 0 0 0",
                  pulses, saw_flag, busy, credit, cycles);
      end
   endtask

   initial begin
      test_reset();
      test_insert();
      test_price_vend();
      test_overflow();
      test_refund();
      test_reset_mid_dispense();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
